// File: rtl/cms_pix28_package.sv
// Command-word layout, op codes, status bit map and decoder state encoding
// shared by the CMS pix28 firmware blocks.
package cms_pix28_package;

  localparam int windex_device_id_hi = 31;
  localparam int windex_device_id_lo = 28;
  localparam int windex_op_code_hi   = 27;
  localparam int windex_op_code_lo   = 24;
  localparam int windex_body_hi      = 23;
  localparam int windex_body_lo      = 0;

  localparam logic [3:0] firmware_id_1 = 4'h1;
  localparam logic [3:0] firmware_id_2 = 4'h2;
  localparam logic [3:0] firmware_id_3 = 4'h4;
  localparam logic [3:0] firmware_id_4 = 4'h8;

  typedef enum logic [3:0] {
    OP_CODE_NOOP              = 4'h0,
    OP_CODE_W_RST_FW          = 4'h1,
    OP_CODE_W_CFG_STATIC_0    = 4'h2,
    OP_CODE_R_CFG_STATIC_0    = 4'h3,
    OP_CODE_W_CFG_STATIC_1    = 4'h4,
    OP_CODE_R_CFG_STATIC_1    = 4'h5,
    OP_CODE_W_CFG_ARRAY_0     = 4'h6,
    OP_CODE_R_CFG_ARRAY_0     = 4'h7,
    OP_CODE_W_CFG_ARRAY_1     = 4'h8,
    OP_CODE_R_CFG_ARRAY_1     = 4'h9,
    OP_CODE_W_CFG_ARRAY_2     = 4'hA,
    OP_CODE_R_CFG_ARRAY_2     = 4'hB,
    OP_CODE_R_DATA_ARRAY_0    = 4'hC,
    OP_CODE_R_DATA_ARRAY_1    = 4'hD,
    OP_CODE_W_STATUS_FW_CLEAR = 4'hE,
    OP_CODE_W_EXECUTE         = 4'hF
  } op_code_t;

  localparam logic [4:0] status_index_rst_fw         = 5'd0;
  localparam logic [4:0] status_index_w_cfg_static_0 = 5'd1;
  localparam logic [4:0] status_index_r_cfg_static_0 = 5'd2;
  localparam logic [4:0] status_index_w_cfg_static_1 = 5'd3;
  localparam logic [4:0] status_index_r_cfg_static_1 = 5'd4;
  localparam logic [4:0] status_index_w_cfg_array_0  = 5'd5;
  localparam logic [4:0] status_index_r_cfg_array_0  = 5'd6;
  localparam logic [4:0] status_index_w_cfg_array_1  = 5'd7;
  localparam logic [4:0] status_index_r_cfg_array_1  = 5'd8;
  localparam logic [4:0] status_index_w_cfg_array_2  = 5'd9;
  localparam logic [4:0] status_index_r_cfg_array_2  = 5'd10;
  localparam logic [4:0] status_index_r_data_array_0 = 5'd11;
  localparam logic [4:0] status_index_r_data_array_1 = 5'd12;
  localparam logic [4:0] status_index_w_execute      = 5'd13;
  localparam logic [4:0] status_index_test1_done     = 5'd14;
  localparam logic [4:0] status_index_test2_done     = 5'd15;
  localparam logic [4:0] status_index_test3_done     = 5'd16;
  localparam logic [4:0] status_index_test4_done     = 5'd17;
  localparam logic [4:0] status_index_execute_err    = 5'd31;

  localparam logic [31:0] STATUS_VALID_MASK = 32'h8003_FFFF;

  typedef enum logic [2:0] {
    IDLE_CD     = 3'd0,
    DECODE_CD   = 3'd1,
    ARR_WAIT_CD = 3'd2,
    RESP_CD     = 3'd3,
    SOFT_RST_CD = 3'd4
  } state_t_sm_cmd_dec;

  localparam logic [2:0] ARR_SEL_CFG_0  = 3'd0;
  localparam logic [2:0] ARR_SEL_CFG_1  = 3'd1;
  localparam logic [2:0] ARR_SEL_CFG_2  = 3'd2;
  localparam logic [2:0] ARR_SEL_DATA_0 = 3'd3;
  localparam logic [2:0] ARR_SEL_DATA_1 = 3'd4;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [2:0] arr_sel_of(input op_code_t op);
    case (op)
      OP_CODE_W_CFG_ARRAY_1, OP_CODE_R_CFG_ARRAY_1: return ARR_SEL_CFG_1;
      OP_CODE_W_CFG_ARRAY_2, OP_CODE_R_CFG_ARRAY_2: return ARR_SEL_CFG_2;
      OP_CODE_R_DATA_ARRAY_0:                       return ARR_SEL_DATA_0;
      OP_CODE_R_DATA_ARRAY_1:                       return ARR_SEL_DATA_1;
      default:                                      return ARR_SEL_CFG_0;
    endcase
  endfunction

  // Completion bit for each op that reports one (execute handled separately).
  function automatic logic [4:0] status_index_of(input op_code_t op);
    case (op)
      OP_CODE_W_CFG_STATIC_0: return status_index_w_cfg_static_0;
      OP_CODE_R_CFG_STATIC_0: return status_index_r_cfg_static_0;
      OP_CODE_W_CFG_STATIC_1: return status_index_w_cfg_static_1;
      OP_CODE_R_CFG_STATIC_1: return status_index_r_cfg_static_1;
      OP_CODE_W_CFG_ARRAY_0:  return status_index_w_cfg_array_0;
      OP_CODE_R_CFG_ARRAY_0:  return status_index_r_cfg_array_0;
      OP_CODE_W_CFG_ARRAY_1:  return status_index_w_cfg_array_1;
      OP_CODE_R_CFG_ARRAY_1:  return status_index_r_cfg_array_1;
      OP_CODE_W_CFG_ARRAY_2:  return status_index_w_cfg_array_2;
      OP_CODE_R_CFG_ARRAY_2:  return status_index_r_cfg_array_2;
      OP_CODE_R_DATA_ARRAY_0: return status_index_r_data_array_0;
      OP_CODE_R_DATA_ARRAY_1: return status_index_r_data_array_1;
      OP_CODE_W_EXECUTE:      return status_index_w_execute;
      default:                return status_index_rst_fw;
    endcase
  endfunction

endpackage

// File: rtl/cms_pix28_status_reg.sv
// Sticky status register: command completion bits, clear, and rising-edge
// capture of the per-test done levels.
module cms_pix28_status_reg
  import cms_pix28_package::*;
(
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic [31:0] set_i,
  input  logic        clr_i,
  input  logic [3:0]  test_done_i,
  output logic [31:0] status_o
);

  logic [31:0] status_q, status_d;
  logic [3:0]  td_prev_q;
  logic [3:0]  td_rise;

  assign td_rise = test_done_i & ~td_prev_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    status_d = clr_i ? '0 : status_q;
    status_d = status_d | set_i;
    // Edges are merged after the clear so a simultaneous done edge survives it.
    status_d[status_index_test1_done +: 4] = status_d[status_index_test1_done +: 4] | td_rise;
    status_d = status_d & STATUS_VALID_MASK;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      status_q  <= '0;
      td_prev_q <= '0;
    end else begin
      status_q  <= status_d;
      td_prev_q <= test_done_i;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/cms_pix28_cmd_decoder.sv
// Host command front-end: filters 32-bit command words by firmware id, decodes
// the op code and drives config registers, array access, execute and responses.
module cms_pix28_cmd_decoder
  import cms_pix28_package::*;
#(
  parameter logic [3:0] FIRMWARE_ID   = firmware_id_1,
  parameter int         RST_FW_CYCLES = 16
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  output logic [23:0] cfg_static_0_reg,
  output logic [23:0] cfg_static_1_reg,
  output logic [23:0] execute_cfg,
  output logic        execute_pulse,
  input  logic        test_busy,
  input  logic [3:0]  test_done,
  output logic        arr_req,
  output logic        arr_wr,
  output logic [2:0]  arr_sel,
  output logic [23:0] arr_wdata,
  input  logic        arr_ack,
  input  logic [31:0] arr_rdata,
  output logic        fw_soft_rst_n,
  output logic [31:0] status_reg
);

  localparam logic [7:0] RST_CNT_INIT = 8'(RST_FW_CYCLES - 1);

  state_t_sm_cmd_dec state_q;
  logic [31:0] cmd_q;
  logic [7:0]  rst_cnt_q;
  logic        cmd_ready_q, resp_valid_q, execute_pulse_q, fw_soft_rst_n_q;
  logic [31:0] resp_data_q;
  logic [23:0] cfg_static_0_q, cfg_static_1_q, execute_cfg_q;
  logic        arr_req_q, arr_wr_q;
  logic [2:0]  arr_sel_q;
  logic [23:0] arr_wdata_q;

  logic [3:0]  cmd_dev_id;
  op_code_t    cmd_op;
  logic [23:0] cmd_body;
  logic        id_match, exec_ok;
  logic [31:0] status_set;
  logic        status_clr;

  assign cmd_dev_id = cmd_q[windex_device_id_hi:windex_device_id_lo];
  assign cmd_op     = op_code_t'(cmd_q[windex_op_code_hi:windex_op_code_lo]);
  assign cmd_body   = cmd_q[windex_body_hi:windex_body_lo];
  assign id_match   = (cmd_dev_id & FIRMWARE_ID) != 4'h0;
  assign exec_ok    = !test_busy && is_onehot4(cmd_body[15:12]);

  // Status updates land on the same edge as the state change they report.
  always_comb begin
    status_set = '0;
    status_clr = 1'b0;
    case (state_q)
      DECODE_CD: begin
        if (id_match) begin
          case (cmd_op)
            OP_CODE_W_RST_FW, OP_CODE_W_STATUS_FW_CLEAR: status_clr = 1'b1;
            OP_CODE_W_CFG_STATIC_0, OP_CODE_R_CFG_STATIC_0,
            OP_CODE_W_CFG_STATIC_1, OP_CODE_R_CFG_STATIC_1:
              status_set[status_index_of(cmd_op)] = 1'b1;
            OP_CODE_W_EXECUTE:
              status_set[exec_ok ? status_index_w_execute : status_index_execute_err] = 1'b1;
            default: ;
          endcase
        end
      end
      ARR_WAIT_CD: if (arr_ack) status_set[status_index_of(cmd_op)] = 1'b1;
      SOFT_RST_CD: if (rst_cnt_q == 8'd0) status_set[status_index_rst_fw] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q         <= IDLE_CD;
      cmd_q           <= '0;
      rst_cnt_q       <= '0;
      cmd_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      execute_pulse_q <= 1'b0;
      fw_soft_rst_n_q <= 1'b1;
      cfg_static_0_q  <= '0;
      cfg_static_1_q  <= '0;
      execute_cfg_q   <= '0;
      arr_req_q       <= 1'b0;
      arr_wr_q        <= 1'b0;
      arr_sel_q       <= '0;
      arr_wdata_q     <= '0;
    end else begin
      execute_pulse_q <= 1'b0;
      case (state_q)
        IDLE_CD: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_q       <= cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= DECODE_CD;
          end
        end
        DECODE_CD: begin
          state_q     <= IDLE_CD;
          cmd_ready_q <= 1'b1;
          if (id_match) begin
            case (cmd_op)
              OP_CODE_W_RST_FW: begin
                state_q         <= SOFT_RST_CD;
                cmd_ready_q     <= 1'b0;
                fw_soft_rst_n_q <= 1'b0;
                rst_cnt_q       <= RST_CNT_INIT;
                cfg_static_0_q  <= '0;
                cfg_static_1_q  <= '0;
                execute_cfg_q   <= '0;
              end
              OP_CODE_W_CFG_STATIC_0: cfg_static_0_q <= cmd_body;
              OP_CODE_W_CFG_STATIC_1: cfg_static_1_q <= cmd_body;
              OP_CODE_R_CFG_STATIC_0, OP_CODE_R_CFG_STATIC_1: begin
                resp_data_q  <= {8'h00, (cmd_op == OP_CODE_R_CFG_STATIC_0) ? cfg_static_0_q
                                                                           : cfg_static_1_q};
                resp_valid_q <= 1'b1;
                cmd_ready_q  <= 1'b0;
                state_q      <= RESP_CD;
              end
              OP_CODE_W_CFG_ARRAY_0, OP_CODE_R_CFG_ARRAY_0,
              OP_CODE_W_CFG_ARRAY_1, OP_CODE_R_CFG_ARRAY_1,
              OP_CODE_W_CFG_ARRAY_2, OP_CODE_R_CFG_ARRAY_2,
              OP_CODE_R_DATA_ARRAY_0, OP_CODE_R_DATA_ARRAY_1: begin
                arr_req_q   <= 1'b1;
                arr_wr_q    <= cmd_op inside {OP_CODE_W_CFG_ARRAY_0, OP_CODE_W_CFG_ARRAY_1,
                                              OP_CODE_W_CFG_ARRAY_2};
                arr_sel_q   <= arr_sel_of(cmd_op);
                arr_wdata_q <= cmd_body;
                cmd_ready_q <= 1'b0;
                state_q     <= ARR_WAIT_CD;
              end
              OP_CODE_W_EXECUTE: begin
                if (exec_ok) begin
                  execute_cfg_q   <= cmd_body;
                  execute_pulse_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ARR_WAIT_CD: begin
          if (arr_ack) begin
            arr_req_q <= 1'b0;
            if (arr_wr_q) begin
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE_CD;
            end else begin
              resp_data_q  <= arr_rdata;
              resp_valid_q <= 1'b1;
              state_q      <= RESP_CD;
            end
          end
        end
        RESP_CD: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            state_q      <= IDLE_CD;
          end
        end
        SOFT_RST_CD: begin
          if (rst_cnt_q == 8'd0) begin
            fw_soft_rst_n_q <= 1'b1;
            cmd_ready_q     <= 1'b1;
            state_q         <= IDLE_CD;
          end else begin
            rst_cnt_q <= rst_cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE_CD;
      endcase
    end
  end

  cms_pix28_status_reg u_status_reg (
    .fw_axi_clk  (fw_axi_clk),
    .fw_rst_n    (fw_rst_n),
    .set_i       (status_set),
    .clr_i       (status_clr),
    .test_done_i (test_done),
    .status_o    (status_reg)
  );

  assign cmd_ready        = cmd_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign cfg_static_0_reg = cfg_static_0_q;
  assign cfg_static_1_reg = cfg_static_1_q;
  assign execute_cfg      = execute_cfg_q;
  assign execute_pulse    = execute_pulse_q;
  assign arr_req          = arr_req_q;
  assign arr_wr           = arr_wr_q;
  assign arr_sel          = arr_sel_q;
  assign arr_wdata        = arr_wdata_q;
  assign fw_soft_rst_n    = fw_soft_rst_n_q;

endmodule
